vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor VGA/DVI raster timing generator for the display path. It produces programmable-resolution sync, data-enable and pixel addresses, and a divided pixel clock for the DAC. It also delays sync/DE to match a configurable frame-buffer read latency, so RGB, sync and DE leave aligned. It sits between the frame-buffer/pattern source (driven by h_addr/v_addr) and the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
CLK_DIV, 2, clk cycles per pixel; legal values 2 or 4
RD_LAT, 1, pixel ticks from address out to valid data_dis; range 0..7
CW, 8, bits per colour channel

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_dis  in  3*CW  pixel {R,G,B}, valid RD_LAT ticks after its address
h_addr  out  11  active-region column, 0 outside active
v_addr  out  11  active-region row, 0 outside active
addr_vld  out  1  h_addr/v_addr name a visible pixel
frame_start  out  1  one-clk pulse with address (0,0)
line_start  out  1  one-clk pulse with h_addr=0 on each active line
hsync  out  1  horizontal sync, aligned to RGB
vsync  out  1  vertical sync, aligned to RGB
vga_de  out  1  data enable (blank active-low equivalent), aligned to RGB
vga_r/vga_g/vga_b  out  CW each  colour, 0 when vga_de=0
vga_clk  out  1  registered pixel clock, period CLK_DIV clk cycles

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). Everything is in the clk domain. vga_clk is an output only and is never used as a clock internally.
- Tick: div_cnt counts 0..CLK_DIV-1. tick=1 when div_cnt==CLK_DIV-1. vga_clk=1 when div_cnt>=CLK_DIV/2. All state below advances only on tick.
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=sum of H params), v_cnt 0..V_TOTAL-1. Origin is the first visible pixel. v_cnt increments when h_cnt wraps; both wrap to 0 together at frame end.
- Stage A, on tick: h_addr/v_addr/addr_vld register the current (h_cnt,v_cnt), then the counters advance. addr_vld=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
- Sync region: hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt. Active level is HS_POL/VS_POL; otherwise the complement.
- Alignment: hs/vs/de pass through a delay line of RD_LAT+1 ticks. data_dis is sampled on the tick RD_LAT ticks after its address. vga_r/g/b/hsync/vsync/vga_de update together, RD_LAT+1 ticks after stage A.
- Pulses: frame_start/line_start are high for exactly one clk cycle (the cycle after the loading tick). line_start also fires on line 0.
- Reset values: counters 0, div_cnt 0, vga_clk 0, h_addr/v_addr 0, addr_vld 0, pulses 0, RGB 0, vga_de 0. hsync=~HS_POL, vsync=~VS_POL. Delay line is filled with inactive levels.
- Reset mid-frame: the frame aborts immediately. The first tick after release presents (0,0) with frame_start.
- Widths: counters 12 bit. Elaboration error if H_TOTAL or V_TOTAL > 4095, CLK_DIV is not in {2,4}, or RD_LAT > 7.

Optional Feature:
VGA_TPG_EN defined:
- Adds input port tpg_en (1 bit).
- When tpg_en=1, an internal 8-bar pattern replaces data_dis at the same pipeline stage, so alignment is unchanged.
- Bars are H_ACTIVE/8 px wide, driven by a bar counter, not a divider.
- Bar order: white, yellow, cyan, green, magenta, red, blue, black. Full scale is all-ones CW.
- tpg_en is sampled on frame_start only.

VGA_TPG_EN undefined: the port is absent, with no pattern logic.

Decomposition:
- Shared package vga_pkg: timing-preset constants (640x480@60, 800x600@72, 1024x768@60); total-length helper functions; colour-bar constants; H_TOTAL/V_TOTAL localparams derived here.
- One sub-module, vga_axis_cnt: a single-axis counter (params ACTIVE/FP/SYNC/BP; inputs en; outputs cnt, wrap, active, sync_act). Instantiated twice: horizontal with en=tick, vertical with en=tick&&h_wrap.

Test Plan:
- Defaults, free-run 2 frames -> frame_start period 840000 clk (800x525 ticks x2); exactly 307200 vga_de-high ticks per frame.
- Defaults -> hsync low for 192 clk, starting 656 ticks after line_start + RD_LAT+1 ticks; vsync low for 2 lines starting at line 490.
- RD_LAT=3, data_dis model returns {h_addr[7:0],v_addr[7:0],8'hA5} after 3 ticks -> at vga_de edge, RGB=(0,0,A5). Pixel (5,7) output = (05,07,A5).
- HS_POL=1, VS_POL=1, CLK_DIV=4 -> hsync high 96 ticks = 384 clk; vga_clk period 4 clk, 50% duty.
- Assert rst_n=0 at line 200 pixel 300 for 3 clk -> all outputs at reset values immediately; first post-release tick gives (0,0) with frame_start.
- VGA_TPG_EN, tpg_en=1 -> pixel 0 RGB=FF,FF,FF; pixel 80 = FF,FF,00; pixel 639 = 00,00,00.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: timing presets, total-length
// helpers, colour-bar constants and the sync/DE control word carried down the pipeline.
package vga_pkg;

    localparam int CNT_W   = 12;
    localparam int ADDR_W  = 11;
    localparam int CNT_MAX = 4095;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    localparam axis_timing_t VGA_640X480_60_H  = '{active: 640,  fp: 16, sync: 96,  bp: 48};
    localparam axis_timing_t VGA_640X480_60_V  = '{active: 480,  fp: 10, sync: 2,   bp: 33};
    localparam axis_timing_t VGA_800X600_72_H  = '{active: 800,  fp: 56, sync: 120, bp: 64};
    localparam axis_timing_t VGA_800X600_72_V  = '{active: 600,  fp: 37, sync: 6,   bp: 23};
    localparam axis_timing_t VGA_1024X768_60_H = '{active: 1024, fp: 24, sync: 136, bp: 160};
    localparam axis_timing_t VGA_1024X768_60_V = '{active: 768,  fp: 3,  sync: 6,   bp: 29};

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int axis_total(input axis_timing_t t);
        return vga_total(t.active, t.fp, t.sync, t.bp);
    endfunction

    // Totals of the default 640x480@60 mode.
    localparam int H_TOTAL = axis_total(VGA_640X480_60_H);
    localparam int V_TOTAL = axis_total(VGA_640X480_60_V);

    // Colour bars, left to right; each bar maps to an on/off mask for {R,G,B}.
    typedef enum logic [2:0] {
        BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
        BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
    } bar_e;

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] mask;
        case (bar_e'(idx))
            BAR_WHITE:   mask = 3'b111;
            BAR_YELLOW:  mask = 3'b110;
            BAR_CYAN:    mask = 3'b011;
            BAR_GREEN:   mask = 3'b010;
            BAR_MAGENTA: mask = 3'b101;
            BAR_RED:     mask = 3'b100;
            BAR_BLUE:    mask = 3'b001;
            default:     mask = 3'b000;
        endcase
        return mask;
    endfunction

    // Sync/DE word delayed alongside the frame-buffer read.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
`ifdef VGA_TPG_EN
        logic [2:0] bar;
`endif
    } vid_ctl_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// Single-axis raster counter: counts 0..TOTAL-1 when en is high and flags the
// active and sync regions of the current position.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync_act
);

    localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYN_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYN_END = CNT_W'(ACTIVE + FP + SYNC);

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values regardless of the order the processes are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    assign wrap     = (cnt == LAST);
    assign active   = (cnt < ACT_END);
    assign sync_act = (cnt >= SYN_BEG) && (cnt < SYN_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/DVI raster timing generator with pixel-clock divider and RD_LAT-matched
// sync/DE alignment. Define VGA_TPG_EN to add the tpg_en colour-bar test pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int RD_LAT   = 1,
    parameter int CW       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef VGA_TPG_EN
    input  logic              tpg_en,
`endif
    input  logic [3*CW-1:0]   data_dis,
    output logic [ADDR_W-1:0] h_addr,
    output logic [ADDR_W-1:0] v_addr,
    output logic              addr_vld,
    output logic              frame_start,
    output logic              line_start,
    output logic              hsync,
    output logic              vsync,
    output logic              vga_de,
    output logic [CW-1:0]     vga_r,
    output logic [CW-1:0]     vga_g,
    output logic [CW-1:0]     vga_b,
    output logic              vga_clk
);

    localparam int H_TOT = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_chk_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end
    if (CLK_DIV != 2 && CLK_DIV != 4) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be 2 or 4");
    end
    if (RD_LAT < 0 || RD_LAT > 7) begin : g_chk_lat
        $error("vga_timing_gen: RD_LAT must be within 0..7");
    end

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);
    localparam vid_ctl_t CTL_IDLE = '{hs: !HS_ON, vs: !VS_ON, default: '0};

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [1:0] DIV_HALF = 2'(CLK_DIV / 2);

    logic [1:0] div_cnt;
    logic [1:0] div_nxt;
    logic       tick;

    assign tick    = (div_cnt == DIV_LAST);
    assign div_nxt = tick ? 2'd0 : div_cnt + 2'd1;

    // vga_clk is registered from the next divider state so it tracks div_cnt exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 2'd0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            vga_clk <= (div_nxt >= DIV_HALF);
        end
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_act, v_act;
    logic             h_sync_act, v_sync_act;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tick),
        .cnt      (h_cnt),
        .wrap     (h_wrap),
        .active   (h_act),
        .sync_act (h_sync_act)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tick && h_wrap),
        .cnt      (v_cnt),
        .wrap     (v_wrap),
        .active   (v_act),
        .sync_act (v_sync_act)
    );

    // The vertical counter wraps together with the horizontal one, so its flag is informational.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

    logic pix_vld;
    logic at_origin;

    assign pix_vld   = h_act && v_act;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TPG_EN
    // Bar position tracks h_cnt with its own counter so no divide by H_ACTIVE/8 is needed.
    localparam logic [ADDR_W-1:0] BAR_LAST = ADDR_W'(H_ACTIVE / 8 - 1);

    logic [ADDR_W-1:0] bar_px;
    logic [2:0]        bar_idx;
    logic              tpg_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_px  <= '0;
            bar_idx <= '0;
            tpg_on  <= 1'b0;
        end else if (tick) begin
            if (at_origin) begin
                tpg_on <= tpg_en;
            end
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px  <= bar_px + 1'b1;
            end
        end
    end

    function automatic logic [3*CW-1:0] bar_pixel(input logic [2:0] idx);
        logic [2:0] mask;
        mask = bar_rgb(idx);
        return {{CW{mask[2]}}, {CW{mask[1]}}, {CW{mask[0]}}};
    endfunction
`endif

    // Stage A: present the current raster position to the pixel source.
    vid_ctl_t stage_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_addr      <= '0;
            v_addr      <= '0;
            addr_vld    <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            stage_a     <= CTL_IDLE;
        end else begin
            frame_start <= tick && at_origin;
            line_start  <= tick && (h_cnt == '0) && v_act;
            if (tick) begin
                addr_vld   <= pix_vld;
                h_addr     <= pix_vld ? h_cnt[ADDR_W-1:0] : '0;
                v_addr     <= pix_vld ? v_cnt[ADDR_W-1:0] : '0;
                stage_a.hs <= h_sync_act ? HS_ON : !HS_ON;
                stage_a.vs <= v_sync_act ? VS_ON : !VS_ON;
                stage_a.de <= pix_vld;
`ifdef VGA_TPG_EN
                stage_a.bar <= bar_idx;
`endif
            end
        end
    end

    // RD_LAT ticks of delay; the output register below supplies the final tick.
    vid_ctl_t tail;

    if (RD_LAT == 0) begin : g_no_dly
        assign tail = stage_a;
    end else begin : g_dly
        vid_ctl_t dly [RD_LAT];

        // NOTE: the delay line is reset to idle levels so no stale sync or DE
        // escapes in the first RD_LAT ticks after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < RD_LAT; i++) begin
                    dly[i] <= CTL_IDLE;
                end
            end else if (tick) begin
                dly[0] <= stage_a;
                for (int i = 1; i < RD_LAT; i++) begin
                    dly[i] <= dly[i-1];
                end
            end
        end

        assign tail = dly[RD_LAT-1];
    end

    logic [3*CW-1:0] pix_src;

    // NOTE: pix_src is assigned a default before any condition so the block stays
    // purely combinational and never infers a latch.
    always_comb begin
        pix_src = data_dis;
`ifdef VGA_TPG_EN
        if (tpg_on) begin
            pix_src = bar_pixel(tail.bar);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= !HS_ON;
            vsync <= !VS_ON;
            vga_de <= 1'b0;
            {vga_r, vga_g, vga_b} <= '0;
        end else if (tick) begin
            hsync <= tail.hs;
            vsync <= tail.vs;
            vga_de <= tail.de;
            {vga_r, vga_g, vga_b} <= tail.de ? pix_src : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default-mode line timing, a small raster with
// RD_LAT=3 and a frame-buffer model, inverted polarities with CLK_DIV=4, mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_s = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- default-parameter instance ----
    logic [23:0] d_data = 24'h123456;
    logic [10:0] d_h_addr, d_v_addr;
    logic        d_addr_vld, d_frame_start, d_line_start, d_hsync, d_vsync, d_vga_de, d_vga_clk;
    logic [7:0]  d_r, d_g, d_b;
    logic [23:0] d_rgb;
    assign d_rgb = {d_r, d_g, d_b};

    vga_timing_gen u_def (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef VGA_TPG_EN
        .tpg_en      (1'b1),
`endif
        .data_dis    (d_data),
        .h_addr      (d_h_addr),
        .v_addr      (d_v_addr),
        .addr_vld    (d_addr_vld),
        .frame_start (d_frame_start),
        .line_start  (d_line_start),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .vga_de      (d_vga_de),
        .vga_r       (d_r),
        .vga_g       (d_g),
        .vga_b       (d_b),
        .vga_clk     (d_vga_clk)
    );

    // ---- small raster, RD_LAT=3: H 16/2/4/2 (24), V 8/2/2/2 (14) ----
    logic [23:0] s_data;
    logic [10:0] s_h_addr, s_v_addr;
    logic        s_addr_vld, s_frame_start, s_line_start, s_hsync, s_vsync, s_vga_de, s_vga_clk;
    logic [7:0]  s_r, s_g, s_b;
    logic [23:0] s_rgb;
    assign s_rgb = {s_r, s_g, s_b};

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2),
        .RD_LAT   (3)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_s),
`ifdef VGA_TPG_EN
        .tpg_en      (1'b0),
`endif
        .data_dis    (s_data),
        .h_addr      (s_h_addr),
        .v_addr      (s_v_addr),
        .addr_vld    (s_addr_vld),
        .frame_start (s_frame_start),
        .line_start  (s_line_start),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .vga_de      (s_vga_de),
        .vga_r       (s_r),
        .vga_g       (s_g),
        .vga_b       (s_b),
        .vga_clk     (s_vga_clk)
    );

    // Frame-buffer model: returns {h,v,A5} three pixel ticks after the address.
    logic        m_phase;
    logic [23:0] m_pipe [3];
    assign s_data = m_pipe[2];

    always @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            m_phase <= 1'b0;
            for (int i = 0; i < 3; i++) m_pipe[i] <= '0;
        end else begin
            m_phase <= ~m_phase;
            if (m_phase) begin
                m_pipe[0] <= {s_h_addr[7:0], s_v_addr[7:0], 8'hA5};
                m_pipe[1] <= m_pipe[0];
                m_pipe[2] <= m_pipe[1];
            end
        end
    end

    // ---- inverted polarities, CLK_DIV=4, default horizontal timing ----
    logic [10:0] p_h_addr, p_v_addr;
    logic        p_addr_vld, p_frame_start, p_line_start, p_hsync, p_vsync, p_vga_de, p_vga_clk;
    logic [7:0]  p_r, p_g, p_b;

    vga_timing_gen #(
        .V_ACTIVE (8), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .HS_POL   (1), .VS_POL (1), .CLK_DIV (4)
    ) u_pol (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef VGA_TPG_EN
        .tpg_en      (1'b0),
`endif
        .data_dis    (24'h0),
        .h_addr      (p_h_addr),
        .v_addr      (p_v_addr),
        .addr_vld    (p_addr_vld),
        .frame_start (p_frame_start),
        .line_start  (p_line_start),
        .hsync       (p_hsync),
        .vsync       (p_vsync),
        .vga_de      (p_vga_de),
        .vga_r       (p_r),
        .vga_g       (p_g),
        .vga_b       (p_b),
        .vga_clk     (p_vga_clk)
    );

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_h_addr",   d_h_addr, 0);
        check("rst_v_addr",   d_v_addr, 0);
        check("rst_addr_vld", d_addr_vld, 0);
        check("rst_pulses",   {d_frame_start, d_line_start}, 0);
        check("rst_hsync",    d_hsync, 1);
        check("rst_vsync",    d_vsync, 1);
        check("rst_de",       d_vga_de, 0);
        check("rst_rgb",      d_rgb, 0);
        check("rst_vga_clk",  d_vga_clk, 0);
        check("rst_pol_sync", {p_hsync, p_vsync}, 2'b00);
        check("rst_small_hs", s_hsync, 1);
        rst_n = 1'b1;
        rst_s = 1'b1;

        fork
            begin : thr_def
                int n, t_ls, rel, de_cyc, hs_lo;
                n = 0;
                while (!d_line_start && n < 100) begin @(negedge clk); n++; end
                check("def_line_start", d_line_start, 1);
                check("def_frame_start", d_frame_start, 1);
                check("def_origin", {d_addr_vld, d_h_addr, d_v_addr}, {1'b1, 22'd0});
                t_ls = cyc; rel = 0; de_cyc = 0;
                while (d_hsync && rel < 3000) begin
                    @(negedge clk);
                    rel = cyc - t_ls;
                    if (d_vga_de) de_cyc++;
                    if (rel == 3) check("def_de_before", d_vga_de, 0);
`ifdef VGA_TPG_EN
                    if (rel == 4)    check("tpg_px0",   d_rgb, 24'hFFFFFF);
                    if (rel == 164)  check("tpg_px80",  d_rgb, 24'hFFFF00);
                    if (rel == 1282) check("tpg_px639", d_rgb, 24'h000000);
`else
                    if (rel == 4)    check("def_px0",   d_rgb, 24'h123456);
`endif
                end
                check("def_hs_fall", rel, 1316);
                check("def_de_line", de_cyc, 1280);
                check("def_rgb_blank", d_rgb, 0);
                hs_lo = 0;
                while (!d_hsync && hs_lo < 1000) begin @(negedge clk); hs_lo++; end
                check("def_hs_low", hs_lo, 192);
            end

            begin : thr_small
                int n, t_fs, rel, de_cyc, vs_fall, vs_lo;
                logic vs_prev;
                n = 0;
                while (!s_frame_start && n < 100) begin @(negedge clk); n++; end
                check("sm_frame_start", s_frame_start, 1);
                t_fs = cyc; rel = 0; de_cyc = 0; vs_fall = -1; vs_lo = 0; vs_prev = s_vsync;
                do begin
                    @(negedge clk);
                    rel = cyc - t_fs;
                    if (s_vga_de) de_cyc++;
                    if (!s_vsync) vs_lo++;
                    if (vs_prev && !s_vsync) vs_fall = rel;
                    vs_prev = s_vsync;
                    if (rel == 7)   check("sm_de_early", s_vga_de, 0);
                    if (rel == 8)   check("sm_rgb_origin", {s_vga_de, s_rgb}, {1'b1, 24'h0000A5});
                    if (rel == 354) check("sm_rgb_5_7", {s_vga_de, s_rgb}, {1'b1, 24'h0507A5});
                end while (!s_frame_start && rel < 1000);
                check("sm_frame_period", rel, 672);
                check("sm_de_frame", de_cyc, 256);
                check("sm_vs_fall", vs_fall, 488);
                check("sm_vs_low", vs_lo, 96);

                n = 0;
                while (!(s_addr_vld && s_h_addr == 11'd10 && s_v_addr == 11'd5) && n < 800) begin
                    @(negedge clk); n++;
                end
                check("sm_pre_rst_de", s_vga_de, 1);
                rst_s = 1'b0;
                #1;
                check("mrst_addr", {s_addr_vld, s_h_addr, s_v_addr}, 0);
                check("mrst_sync", {s_hsync, s_vsync}, 2'b11);
                check("mrst_de_rgb", {s_vga_de, s_rgb}, 0);
                check("mrst_misc", {s_frame_start, s_line_start, s_vga_clk}, 0);
                repeat (3) @(negedge clk);
                check("mrst_hold", {s_vga_de, s_addr_vld, s_hsync}, 3'b001);
                rst_s = 1'b1;
                @(negedge clk);
                check("mrst_first_clk", s_frame_start, 0);
                @(negedge clk);
                check("mrst_frame_start", s_frame_start, 1);
                check("mrst_origin", {s_addr_vld, s_h_addr, s_v_addr}, {1'b1, 22'd0});
            end

            begin : thr_pol
                int highs, rises, n, hs_hi;
                logic prev;
                highs = 0; rises = 0; prev = p_vga_clk;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (p_vga_clk) highs++;
                    if (!prev && p_vga_clk) rises++;
                    prev = p_vga_clk;
                end
                check("pol_clk_high", highs, 20);
                check("pol_clk_rises", rises, 10);
                n = 0;
                while (!p_hsync && n < 4000) begin @(negedge clk); n++; end
                check("pol_vs_idle", p_vsync, 0);
                hs_hi = 0;
                while (p_hsync && hs_hi < 1000) begin @(negedge clk); hs_hi++; end
                check("pol_hs_high", hs_hi, 384);
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
